spi_master_gen: RTL and testbench

- Generalised SPI master for PMU converter/monitor chips. Runs write frames and read frames (command, optional CS-high gap, readback).
- Supports all four SPI modes, configurable command and readback widths, and NUM_SDO parallel readback lanes sharing one sclk/cs_n.
- Sits between PMU register-access control logic and external ADC/DAC/monitor devices.

---
 rtl/spi_master_gen.sv | 133 +++++++++++++
 tb/tb_spi_master_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
// spi_master_gen: SPI master running write frames and read frames (command, optional CS-high gap, readback)
// over NUM_SDO parallel readback lanes in any of the four SPI modes.
module spi_master_gen #(
  parameter int DIVIDE    = 4,
  parameter int CMD_WIDTH = 24,
  parameter int RD_WIDTH  = 24,
  parameter int NUM_SDO   = 2,
  parameter int WAIT_CYC  = 20,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_req,
  input  logic                         rd_req,
  input  logic [CMD_WIDTH-1:0]         tx_data,
  output logic                         ready,
  output logic                         wr_done,
  output logic                         rd_done,
  output logic                         cs_n,
  output logic                         sclk,
  output logic                         mosi,
  input  logic [NUM_SDO-1:0]           miso,
  output logic [NUM_SDO*RD_WIDTH-1:0]  rd_data,
  output logic                         rd_data_vld
);
  localparam int H  = DIVIDE / 2;
  localparam int M1 = CMD_WIDTH > RD_WIDTH ? CMD_WIDTH : RD_WIDTH;
  localparam int MX = M1 > WAIT_CYC ? M1 : WAIT_CYC;
  localparam int BW = $clog2(MX + 1);
  localparam int DW = $clog2(DIVIDE);
  localparam logic [DW-1:0] D_LEAD = DW'(H - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIVIDE - 1);
  localparam logic [BW-1:0] C_LAST = BW'(CMD_WIDTH - 1);
  localparam logic [BW-1:0] R_LAST = BW'(RD_WIDTH - 1);
  localparam logic [BW-1:0] W_LAST = BW'(WAIT_CYC - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] RD   = 2'd3;
  logic [1:0]                    state;
  logic                          rd_frame;
  logic [CMD_WIDTH-1:0]          sh, nxt;
  logic [DW-1:0]                 div;
  logic [BW-1:0]                 cnt;
  logic [NUM_SDO*RD_WIDTH-1:0]   lane, lane_nx;
  logic                          lead, trail, last, smp;
  function automatic logic first_bit(input logic [CMD_WIDTH-1:0] x);
    return LSB_FIRST ? x[0] : x[CMD_WIDTH-1];
  endfunction
  assign ready = state == IDLE;
  always_comb begin
    lead  = div == D_LEAD;
    trail = div == D_LAST;
    last  = cnt == (state == CMD ? C_LAST : state == GAP ? W_LAST : R_LAST);
    smp   = state == RD && (CPHA ? trail : lead);
    nxt   = LSB_FIRST ? sh >> 1 : sh << 1;
    lane_nx = lane;
    for (int k = 0; k < NUM_SDO; k++)
      lane_nx[k*RD_WIDTH +: RD_WIDTH] = LSB_FIRST
        ? (lane[k*RD_WIDTH +: RD_WIDTH] >> 1) | (RD_WIDTH'(miso[k]) << (RD_WIDTH - 1))
        : (lane[k*RD_WIDTH +: RD_WIDTH] << 1) | RD_WIDTH'(miso[k]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_frame    <= 1'b0;
      cs_n        <= 1'b1;
      sclk        <= CPOL;
      mosi        <= 1'b1;
      rd_data     <= '0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      rd_data_vld <= 1'b0;
      div         <= '0;
      cnt         <= '0;
      sh          <= '0;
      lane        <= '0;
    end else begin
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      rd_data_vld <= 1'b0;
      if (state == IDLE) begin
        if (wr_req || rd_req) begin
          state    <= CMD;
          rd_frame <= !wr_req;
          sh       <= tx_data;
          mosi     <= first_bit(tx_data);
          cs_n     <= 1'b0;
          div      <= '0;
          cnt      <= '0;
        end
      end else begin
        div <= trail ? '0 : div + 1'b1;
        if (state != GAP && lead) sclk <= ~CPOL;
        if (state != GAP && trail) sclk <= CPOL;
        if (state == CMD && CPHA && lead) mosi <= first_bit(sh);
        if (smp) lane <= lane_nx;
        if (trail) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (state == CMD) begin
            sh <= nxt;
            if (!CPHA) mosi <= first_bit(nxt);
          end
          // the final capture of a CPHA=1 read lands on the same edge that ends the frame
          if (last) begin
            if (state == CMD && !rd_frame) begin
              state   <= IDLE;
              cs_n    <= 1'b1;
              mosi    <= 1'b1;
              wr_done <= 1'b1;
            end else if (state == CMD && WAIT_CYC > 0) begin
              state <= GAP;
              cs_n  <= 1'b1;
              mosi  <= 1'b1;
            end else if (state == CMD || state == GAP) begin
              state <= RD;
              cs_n  <= 1'b0;
              mosi  <= 1'b1;
            end else begin
              state       <= IDLE;
              cs_n        <= 1'b1;
              rd_data     <= smp ? lane_nx : lane;
              rd_done     <= 1'b1;
              rd_data_vld <= 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master_gen.sv
// tb_spi_master_gen: four masters (one per SPI mode) against behavioural loopback slaves and edge monitors.
module tb_spi_master_gen;
  localparam int D  = 4;
  localparam int CW = 8;
  localparam int RW = 8;
  localparam int NS = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic wr_req[4], rd_req[4], ready[4], wr_done[4], rd_done[4];
  logic cs_n[4], sclk[4], mosi[4], rd_data_vld[4];
  logic [CW-1:0]    tx_data[4];
  logic [NS-1:0]    miso[4];
  logic [NS*RW-1:0] rd_data[4];
  int lead_n[4], trail_n[4], low_n[4], gap_n[4], wd_n[4], rdn_n[4], mism_n[4], idle_bad[4], mcnt[4];
  logic [63:0] mlog[4];
  logic ps[4], pm[4];
  int lbase[4], tbase[4];
  logic [RW-1:0] sw[4][2];
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int         g;
    bit         wr;
    logic [7:0] tx;
    logic [7:0] w0;
    logic [7:0] w1;
  } vec_t;
  vec_t tbl[7];
  function automatic bit cpol(input int g); return g >= 2; endfunction
  function automatic bit cpha(input int g); return g % 2 == 1; endfunction
  function automatic bit lsb(input int g); return g == 3; endfunction
  function automatic int waitc(input int g); return g == 3 ? 0 : 2; endfunction
  function automatic logic sbit(input logic [RW-1:0] w, input int i, input bit l);
    if (i < 0 || i >= RW) return 1'b1;
    return l ? 1'(w >> i) : 1'(w >> (RW - 1 - i));
  endfunction
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_gen #(
      .DIVIDE(D), .CMD_WIDTH(CW), .RD_WIDTH(RW), .NUM_SDO(NS), .WAIT_CYC(g == 3 ? 0 : 2),
      .CPOL(g >= 2), .CPHA(g % 2 == 1), .LSB_FIRST(g == 3)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req[g]), .rd_req(rd_req[g]), .tx_data(tx_data[g]),
      .ready(ready[g]), .wr_done(wr_done[g]), .rd_done(rd_done[g]), .cs_n(cs_n[g]), .sclk(sclk[g]),
      .mosi(mosi[g]), .miso(miso[g]), .rd_data(rd_data[g]), .rd_data_vld(rd_data_vld[g])
    );
  end
  // slave: readback bit index is the count of driving edges since the request, minus the command bits
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      miso[g] = '1;
      for (int k = 0; k < NS; k++)
        miso[g][k] = sbit(sw[g][k], (cpha(g) ? lead_n[g] - lbase[g] - 1 : trail_n[g] - tbase[g]) - CW, lsb(g));
    end
  end
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (sclk[g] !== ps[g]) begin
        if (sclk[g] != cpol(g)) lead_n[g] <= lead_n[g] + 1;
        else trail_n[g] <= trail_n[g] + 1;
        if (sclk[g] == (cpha(g) ? cpol(g) : !cpol(g))) begin
          mlog[g] <= {mlog[g][62:0], pm[g]};
          mcnt[g] <= mcnt[g] + 1;
        end
      end
      ps[g]       <= sclk[g];
      pm[g]       <= mosi[g];
      low_n[g]    <= low_n[g] + int'(cs_n[g] == 1'b0);
      gap_n[g]    <= gap_n[g] + int'(cs_n[g] == 1'b1 && ready[g] == 1'b0);
      wd_n[g]     <= wd_n[g] + int'(wr_done[g] == 1'b1);
      rdn_n[g]    <= rdn_n[g] + int'(rd_done[g] == 1'b1);
      mism_n[g]   <= mism_n[g] + int'(rd_done[g] !== rd_data_vld[g]);
      idle_bad[g] <= idle_bad[g] + int'(ready[g] == 1'b1 && sclk[g] != cpol(g));
    end
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic run(input int g, input bit wr, input logic [7:0] tx, input logic [7:0] w0,
                     input logic [7:0] w1, input string nm);
    int l0, lo0, ga0, wd0, rd0, mm0, ib0, mc0, nb, c;
    logic [7:0] mw;
    logic b, ones;
    @(negedge clk);
    sw[g][0] = w0; sw[g][1] = w1;
    lbase[g] = lead_n[g]; tbase[g] = trail_n[g];
    l0 = lead_n[g]; lo0 = low_n[g]; ga0 = gap_n[g]; wd0 = wd_n[g]; rd0 = rdn_n[g];
    mm0 = mism_n[g]; ib0 = idle_bad[g]; mc0 = mcnt[g];
    wr_req[g] = wr; rd_req[g] = !wr; tx_data[g] = tx;
    @(negedge clk);
    wr_req[g] = 1'b0; rd_req[g] = 1'b0; tx_data[g] = ~tx;
    chk({nm, " busy"}, ready[g], 0);
    c = 0;
    while (c < 1000 && (wr ? wr_done[g] : rd_done[g]) !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " done seen"}, c < 1000, 1);
    chk({nm, " cs_n end"}, cs_n[g], 1);
    chk({nm, " sclk end"}, sclk[g], cpol(g));
    chk({nm, " ready end"}, ready[g], 1);
    if (!wr) chk({nm, " rd_data"}, rd_data[g], {w1, w0});
    repeat (3) @(negedge clk);
    chk({nm, " lead edges"}, lead_n[g] - l0, wr ? CW : CW + RW);
    chk({nm, " cs low cycles"}, low_n[g] - lo0, (wr ? CW : CW + RW) * D);
    chk({nm, " gap cycles"}, gap_n[g] - ga0, wr ? 0 : waitc(g) * D);
    chk({nm, " wr_done pulses"}, wd_n[g] - wd0, wr ? 1 : 0);
    chk({nm, " rd_done pulses"}, rdn_n[g] - rd0, wr ? 0 : 1);
    chk({nm, " vld/done align"}, mism_n[g] - mm0, 0);
    chk({nm, " idle sclk"}, idle_bad[g] - ib0, 0);
    nb = mcnt[g] - mc0;
    chk({nm, " sample edges"}, nb, wr ? CW : CW + RW);
    mw = '0;
    ones = 1'b1;
    for (int i = 0; i < nb && i < 64; i++) begin
      b = 1'(mlog[g] >> (nb - 1 - i));
      if (i < CW) mw = lsb(g) ? {b, mw[7:1]} : {mw[6:0], b};
      else ones = ones & b;
    end
    chk({nm, " first mosi bit"}, 1'(mlog[g] >> (nb - 1)), lsb(g) ? tx[0] : tx[7]);
    chk({nm, " mosi word"}, mw, tx);
    if (!wr) chk({nm, " mosi idle in RD"}, ones, 1);
  endtask
  initial begin
    int c, wd0, rd0;
    tbl[0] = '{0, 1'b1, 8'hA5, 8'h00, 8'h00};
    tbl[1] = '{0, 1'b0, 8'h96, 8'h3C, 8'hC3};
    tbl[2] = '{1, 1'b0, 8'h5A, 8'h81, 8'h7E};
    tbl[3] = '{2, 1'b0, 8'hC7, 8'h12, 8'hED};
    tbl[4] = '{3, 1'b0, 8'h01, 8'hB4, 8'h4B};
    tbl[5] = '{3, 1'b1, 8'h01, 8'h00, 8'h00};
    tbl[6] = '{2, 1'b1, 8'h3E, 8'h00, 8'h00};
    for (int g = 0; g < 4; g++) begin
      wr_req[g] = 1'b0; rd_req[g] = 1'b0; tx_data[g] = '0;
      sw[g][0] = '0; sw[g][1] = '0; lbase[g] = 0; tbase[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("reset cs_n", cs_n[g], 1);
      chk("reset sclk", sclk[g], cpol(g));
      chk("reset mosi", mosi[g], 1);
      chk("reset rd_data", rd_data[g], 0);
      chk("reset ready", ready[g], 1);
      chk("reset pulses", {wr_done[g], rd_done[g], rd_data_vld[g]}, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++)
      run(tbl[i].g, tbl[i].wr, tbl[i].tx, tbl[i].w0, tbl[i].w1, $sformatf("vec%0d", i));
    // simultaneous requests, then a held read request during the write
    @(negedge clk);
    sw[0][0] = 8'h11; sw[0][1] = 8'h22;
    rd0 = rdn_n[0];
    wr_req[0] = 1'b1; rd_req[0] = 1'b1; tx_data[0] = 8'h5A;
    @(negedge clk);
    wr_req[0] = 1'b0;
    c = 0;
    while (c < 1000 && wr_done[0] !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    chk("both req wr_done", c < 1000, 1);
    chk("both req no rd_done", rdn_n[0] - rd0, 0);
    chk("both req cs_n between", cs_n[0], 1);
    @(posedge clk);
    #1;
    lbase[0] = lead_n[0]; tbase[0] = trail_n[0];
    rd_req[0] = 1'b0;
    chk("held rd accepted", ready[0], 0);
    c = 0;
    while (c < 1000 && rd_done[0] !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    chk("held rd done", c < 1000, 1);
    chk("held rd data", rd_data[0], 16'h2211);
    repeat (3) @(negedge clk);
    chk("held rd single frame", rdn_n[0] - rd0, 1);
    // reset in the middle of a command phase
    @(negedge clk);
    wd0 = wd_n[1];
    wr_req[1] = 1'b1; tx_data[1] = 8'hF0;
    @(negedge clk);
    wr_req[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid-CMD busy", cs_n[1], 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort cs_n", cs_n[1], 1);
    chk("abort sclk", sclk[1], cpol(1));
    chk("abort ready", ready[1], 1);
    chk("abort mosi", mosi[1], 1);
    repeat (40) @(negedge clk);
    chk("abort no done", wd_n[1] - wd0, 0);
    run(1, 1'b1, 8'h69, 8'h00, 8'h00, "after abort");
    for (int i = 0; i < 20; i++)
      run($urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
          $sformatf("rand%0d", i));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
